// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32 funct3 widths,
// byte-lane mask constants and small width/alignment helpers.
package lsu_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_FAULT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_NONE = 4'hf;
    localparam logic [3:0] MASK_ALL  = 4'h0;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Unused funct3 codes fall through to word.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane decoder shared by the load and store paths: extracts and extends
// load data, and builds replicated store data plus the write mask.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o,
    output logic [3:0]  store_mask_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        sign_ext;

    always_comb begin
        case (addr_lo_i)
            2'd0:    lane_byte = rdata_i[7:0];
            2'd1:    lane_byte = rdata_i[15:8];
            2'd2:    lane_byte = rdata_i[23:16];
            default: lane_byte = rdata_i[31:24];
        endcase
        lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_ext  = ~funct3_i[2];
    end

    always_comb begin
        load_data_o  = rdata_i;
        store_data_o = wdata_i;
        store_mask_o = MASK_ALL;
        case (f3_size(funct3_i))
            SZ_BYTE: begin
                load_data_o  = {{24{sign_ext & lane_byte[7]}}, lane_byte};
                store_data_o = {4{wdata_i[7:0]}};
                store_mask_o = ~(4'b0001 << addr_lo_i);
            end
            SZ_HALF: begin
                load_data_o  = {{16{sign_ext & lane_half[15]}}, lane_half};
                store_data_o = {2{wdata_i[15:0]}};
                store_mask_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                load_data_o  = rdata_i;
                store_data_o = wdata_i;
                store_mask_o = MASK_ALL;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU memory stage: one load/store at a time towards memory_bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [15:0] bus_address,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    output logic [3:0]  bus_write_mask,
    output logic        bus_enable,
    output logic        bus_write_enable
);

    // Counter counts down to zero; the read is captured on the terminal cycle.
    localparam logic [2:0] RW_CNT = 3'(READ_WAIT - 1);

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;

    logic [31:0] lane_load;
    logic [31:0] lane_store;
    logic [3:0]  lane_mask;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{req_address[31:16], write_q};

    lsu_lane_align u_align (
        .funct3_i     (funct3_q),
        .addr_lo_i    (addr_q[1:0]),
        .rdata_i      (bus_data_in),
        .wdata_i      (wdata_q),
        .load_data_o  (lane_load),
        .store_data_o (lane_store),
        .store_mask_o (lane_mask)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d     = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    wdata_d  = req_store_data;
                    cnt_d    = RW_CNT;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d  = req_address[15:0];
                    fault_d = is_misaligned(req_funct3, req_address[1:0]);
                    if (fault_d)        state_d = ST_FAULT;
                    else if (req_write) state_d = ST_WRITE;
                    else                state_d = ST_READ;
`else
                    addr_d  = {req_address[15:2], align_lo(req_funct3, req_address[1:0])};
                    state_d = req_write ? ST_WRITE : ST_READ;
`endif
                end
            end
            ST_READ: begin
                if (cnt_q == 3'd0) begin
                    load_data_d = lane_load;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_FAULT: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 3'd0;
            load_data_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign load_data        = load_data_q;
    assign bus_address      = {addr_q[15:2], 2'b00};
    assign bus_data_out     = lane_store;
    assign bus_enable       = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign bus_write_enable = (state_q == ST_WRITE);
    assign bus_write_mask   = bus_write_enable ? lane_mask : MASK_NONE;

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = done & fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (READ_WAIT 1 and 3) driven in turn
// against a byte-array reference memory and a simple memory_bus model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_store_data = 32'd0;
    logic        sel = 1'b0;

    logic [1:0]  busy_v, done_v, fault_v, be_v, we_v;
    logic [31:0] ld_v [2];
    logic [31:0] bdo_v [2];
    logic [15:0] ba_v [2];
    logic [3:0]  bm_v [2];
    logic [31:0] bus_rdata;

    logic        busy, done, fault, be, we;
    logic [31:0] ld, bdo;
    logic [15:0] ba;
    logic [3:0]  bm;

    logic [31:0] mem [0:16383];
    logic [7:0]  ref_mem [0:65535];

    int          checks = 0;
    int          errors = 0;
    int          rw = 1;
    logic [31:0] ld_exp = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.READ_WAIT(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1'b0),
        .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
        .req_store_data(req_store_data), .busy(busy_v[0]), .done(done_v[0]),
        .load_data(ld_v[0]), .fault(fault_v[0]), .bus_address(ba_v[0]),
        .bus_data_out(bdo_v[0]), .bus_data_in(bus_rdata), .bus_write_mask(bm_v[0]),
        .bus_enable(be_v[0]), .bus_write_enable(we_v[0])
    );

    load_store_unit #(.READ_WAIT(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1'b1),
        .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
        .req_store_data(req_store_data), .busy(busy_v[1]), .done(done_v[1]),
        .load_data(ld_v[1]), .fault(fault_v[1]), .bus_address(ba_v[1]),
        .bus_data_out(bdo_v[1]), .bus_data_in(bus_rdata), .bus_write_mask(bm_v[1]),
        .bus_enable(be_v[1]), .bus_write_enable(we_v[1])
    );

    assign busy  = busy_v[sel];
    assign done  = done_v[sel];
    assign fault = fault_v[sel];
    assign be    = be_v[sel];
    assign we    = we_v[sel];
    assign ld    = ld_v[sel];
    assign bdo   = bdo_v[sel];
    assign ba    = ba_v[sel];
    assign bm    = bm_v[sel];

    // memory_bus stand-in: combinational read, byte-masked write on the clock
    assign bus_rdata = mem[ba[15:2]];

    always @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (!bm[i]) mem[ba[15:2]][8*i +: 8] <= bdo[8*i +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (rw=%0d): got 0x%08h expected 0x%08h", tag, rw, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit traps(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr[15:0] % nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] eff_addr(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        a = int'(addr[15:0]);
        return 16'(a - (a % nbytes(f3)));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [15:0] ea);
        int n;
        logic [63:0] v;
        n = nbytes(f3);
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(ea) + i]) << (8 * i));
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int          n, exp_lat, exp_be, done_cyc, be_n, we_n, lo;
        bit          tr;
        logic [15:0] ea, ba_first;
        logic [3:0]  mask_seen, exp_mask;
        logic [31:0] dout_seen, exp_dout, ld_seen;
        logic        fault_seen;
        n = nbytes(f3);
        tr = traps(f3, addr);
        ea = eff_addr(f3, addr);
        exp_lat = tr ? 2 : (wr ? 2 : rw + 1);
        exp_be  = tr ? 0 : (wr ? 1 : rw);
        done_cyc = 0; be_n = 0; we_n = 0;
        mask_seen = 4'hf; dout_seen = 32'd0; ld_seen = 32'd0; fault_seen = 1'b0; ba_first = 16'd0;
        @(negedge clk);
        check_val({tag, " idle busy"}, 32'(busy), 32'd0);
        req_write = wr; req_funct3 = f3; req_address = addr; req_store_data = data;
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req_valid = 1'b0;
                ba_first = ba;
            end
            if (be) be_n++;
            if (we) begin
                we_n++;
                mask_seen = bm;
                dout_seen = bdo;
            end
            if (done) begin
                done_cyc = cyc;
                fault_seen = fault;
                ld_seen = ld;
                break;
            end
        end
        if (done_cyc == 0) check_val({tag, " done timeout"}, 32'd0, 32'd1);
        check_val({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check_val({tag, " bus_enable cycles"}, 32'(be_n), 32'(exp_be));
        check_val({tag, " write_enable cycles"}, 32'(we_n), wr && !tr ? 32'd1 : 32'd0);
        check_val({tag, " fault"}, 32'(fault_seen), 32'(tr));
        if (!tr) check_val({tag, " bus_address"}, 32'(ba_first), 32'({ea[15:2], 2'b00}));
        if (wr && !tr) begin
            lo = int'(ea[1:0]);
            exp_mask = 4'hf;
            for (int i = 0; i < n; i++) exp_mask[lo + i] = 1'b0;
            exp_dout = (n == 1) ? {4{data[7:0]}} : (n == 2) ? {2{data[15:0]}} : data;
            check_val({tag, " mask"}, 32'(mask_seen), 32'(exp_mask));
            check_val({tag, " bus_data_out"}, dout_seen, exp_dout);
            for (int i = 0; i < n; i++) ref_mem[int'(ea) + i] = data[8*i +: 8];
        end
        if (!wr && !tr) ld_exp = model_load(f3, ea);
        check_val({tag, " load_data"}, ld_seen, ld_exp);
    endtask

    task automatic reset_during_read();
        int dn;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0000_0004;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("rst-mid busy before", 32'(busy), 32'd1);
        check_val("rst-mid bus_enable before", 32'(be), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("rst-mid busy after", 32'(busy), 32'd0);
        check_val("rst-mid bus_enable after", 32'(be), 32'd0);
        dn = int'(done);
        for (int c = 0; c < rw + 3; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check_val("rst-mid no done", 32'(dn), 32'd0);
        ld_exp = 32'd0;
    endtask

    task automatic back_to_back();
        int dones, last;
        dones = 0; last = 0;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0000_0004;
        req_valid = 1'b1;
        for (int c = 1; c <= 3 * (rw + 2); c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) check_val("b2b first done", 32'(c), 32'(rw + 1));
                else            check_val("b2b spacing", 32'(c - last), 32'(rw + 2));
                check_val("b2b load_data", ld, model_load(3'b010, 16'h0004));
                last = c;
            end
            if (c == 3 * (rw + 2)) req_valid = 1'b0;
        end
        check_val("b2b done count", 32'(dones), 32'd3);
        ld_exp = model_load(3'b010, 16'h0004);
    endtask

    task automatic run_suite(input logic s, input int r);
        logic [2:0]  f3;
        bit          wr;
        logic [31:0] addr;
        sel = s;
        rw = r;
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst fault", 32'(fault), 32'd0);
        check_val("rst bus_enable", 32'(be), 32'd0);
        check_val("rst write_enable", 32'(we), 32'd0);
        check_val("rst load_data", ld, 32'd0);
        check_val("rst bus_data_out", bdo, 32'd0);
        check_val("rst bus_address", 32'(ba), 32'd0);
        check_val("rst write_mask", 32'(bm), 32'hf);
        reset = 1'b1;
        ld_exp = 32'd0;

        access(1, 3'b010, 32'h0000_0004, 32'hdeadbeef, "t1 SW");
        access(0, 3'b010, 32'h0000_0004, 32'd0, "t1 LW");
        check_val("t1 LW value", ld_exp, 32'hdeadbeef);
        access(1, 3'b000, 32'h0000_0006, 32'h0000_0080, "t2 SB");
        access(0, 3'b000, 32'h0000_0006, 32'd0, "t2 LB");
        check_val("t2 LB value", ld_exp, 32'hffffff80);
        access(0, 3'b100, 32'h0000_0006, 32'd0, "t2 LBU");
        check_val("t2 LBU value", ld_exp, 32'h00000080);
        access(1, 3'b001, 32'h0000_0002, 32'h0000_8001, "t3 SH");
        access(0, 3'b001, 32'h0000_0002, 32'd0, "t3 LH");
        check_val("t3 LH value", ld_exp, 32'hffff8001);
        access(0, 3'b101, 32'h0000_0002, 32'd0, "t3 LHU");
        check_val("t3 LHU value", ld_exp, 32'h00008001);
        access(0, 3'b010, 32'h0000_0003, 32'd0, "t4 LW misaligned");
        reset_during_read();
        access(1, 3'b010, 32'h0000_c000, 32'h1234_5678, "t5 SW");
        access(0, 3'b010, 32'h0000_c000, 32'd0, "t5 LW");
        back_to_back();

        for (int k = 0; k < 60; k++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hffff_0000) | 32'($urandom_range(0, 31));
            access(wr, f3, addr, $urandom, wr ? "rnd store" : "rnd load");
        end
    endtask

    initial begin
        run_suite(1'b0, 1);
        run_suite(1'b1, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
